// File: rtl/dt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dt_pkg : shared constants, state encoding and per-pixel stat update   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package dt_pkg;

  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int ADDR_W  = 14;
  localparam int PIX_W   = 8;
  localparam int PIX_CNT = IMG_W * IMG_H;
  // Counters must hold PIX_CNT itself, the sum must hold PIX_CNT * max pixel.
  localparam int CNT_W   = $clog2(PIX_CNT + 1);
  localparam int SUM_W   = $clog2(PIX_CNT * ((1 << PIX_W) - 1) + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0]  max_dist;
    logic [ADDR_W-1:0] max_addr;
    logic [CNT_W-1:0]  obj_cnt;
    logic [SUM_W-1:0]  dist_sum;
    logic [CNT_W-1:0]  thr_cnt;
  } stats_t;

  // Strict compare on the max keeps the lowest address on ties.
  function automatic stats_t stats_update(
    input stats_t            s,
    input logic [PIX_W-1:0]  pix,
    input logic [ADDR_W-1:0] addr,
    input logic [PIX_W-1:0]  thr
  );
    stats_t r;
    r = s;
    if (pix > s.max_dist) begin
      r.max_dist = pix;
      r.max_addr = addr;
    end
    if (pix != '0) r.obj_cnt = s.obj_cnt + CNT_W'(1);
    r.dist_sum = s.dist_sum + SUM_W'(pix);
    if (pix >= thr) r.thr_cnt = s.thr_cnt + CNT_W'(1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dt_stat_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dt_stat_acc : read-pipeline register plus running image statistics    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dt_stat_acc
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  pix,
  input  logic [PIX_W-1:0]  thr_q,
  input  logic              load,
  output stats_t            stats
);

  logic              vld;
  logic [ADDR_W-1:0] addr_d;
  stats_t            work;
  stats_t            work_nxt;

  always_comb begin
    work_nxt = work;
    if (clr) begin
      work_nxt = '0;
    end else if (vld) begin
      work_nxt = stats_update(work, pix, addr_d, thr_q);
    end
  end

  // Outputs take work_nxt so the final pixel lands in the same edge as load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld    <= 1'b0;
      addr_d <= '0;
      work   <= '0;
      stats  <= '0;
    end else begin
      vld    <= rd_en;
      addr_d <= rd_addr;
      work   <= work_nxt;
      if (load) stats <= work_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dt_stat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dt_stat : scans the distance map once per start and reports stats     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module dt_stat
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        thr,
  output logic              res_rd,
  output logic [13:0]       res_addr,
  input  logic [7:0]        res_di,
  output logic              busy,
  output logic              done,
  output logic [7:0]        max_dist,
  output logic [13:0]       max_addr,
  output logic [14:0]       obj_cnt,
  output logic [21:0]       dist_sum,
  output logic [14:0]       thr_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [PIX_W-1:0]  thr_q;
  logic              accept;
  logic              last_addr;
  stats_t            stats;

  assign last_addr = (addr_q == ADDR_W'(PIX_CNT - 1));

  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (last_addr) state_nxt = DRAIN;
        else           addr_nxt  = addr_q + ADDR_W'(1);
      end
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      addr_q <= '0;
      thr_q  <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      if (accept) thr_q <= thr;
    end
  end

  assign res_rd   = (state == SCAN);
  assign res_addr = res_rd ? addr_q : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  dt_stat_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .rd_en   (res_rd),
    .rd_addr (res_addr),
    .pix     (res_di),
    .thr_q   (thr_q),
    .load    (state == DRAIN),
    .stats   (stats)
  );

  assign max_dist = stats.max_dist;
  assign max_addr = stats.max_addr;
  assign obj_cnt  = stats.obj_cnt;
  assign dist_sum = stats.dist_sum;
  assign thr_cnt  = stats.thr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dt_stat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dt_stat : directed scans against a whole-map statistics model      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_dt_stat;

  localparam int NPIX   = 16384;
  localparam int DONE_C = 16386;
  localparam int BOUND  = 20000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  thr;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        busy;
  logic        done;
  logic [7:0]  max_dist;
  logic [13:0] max_addr;
  logic [14:0] obj_cnt;
  logic [21:0] dist_sum;
  logic [14:0] thr_cnt;

  logic [7:0]  mem [0:NPIX-1];

  int          checks;
  int          errors;

  // Model: cycle index since accepted start (0 = idle) and expected stats.
  int          sc;
  logic [7:0]  thr_m;
  int          e_max;
  int          e_maxa;
  int          e_obj;
  int          e_sum;
  int          e_thr;

  dt_stat dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .busy     (busy),
    .done     (done),
    .max_dist (max_dist),
    .max_addr (max_addr),
    .obj_cnt  (obj_cnt),
    .dist_sum (dist_sum),
    .thr_cnt  (thr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_stats();
    e_max = 0; e_maxa = 0; e_obj = 0; e_sum = 0; e_thr = 0;
    for (int a = 0; a < NPIX; a++) begin
      if (int'(mem[a]) > e_max) begin
        e_max  = int'(mem[a]);
        e_maxa = a;
      end
      if (mem[a] != 8'd0) e_obj++;
      e_sum += int'(mem[a]);
      if (mem[a] >= thr_m) e_thr++;
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      sc = 0;
      e_max = 0; e_maxa = 0; e_obj = 0; e_sum = 0; e_thr = 0;
    end else if (sc == 0) begin
      if (start) begin
        sc    = 1;
        thr_m = thr;
      end
    end else if (sc == DONE_C) begin
      sc = 0;
    end else begin
      sc++;
      if (sc == DONE_C) model_stats();
    end
  endtask

  task automatic tick();
    logic        xr;
    logic [13:0] xa;
    @(posedge clk);
    model_step();
    #1;
    xr = (sc >= 1) && (sc <= NPIX);
    xa = xr ? 14'(sc - 1) : 14'd0;
    chk("ctrl{busy,rd,done,addr}", 64'({busy, res_rd, done, res_addr}),
        64'({sc != 0, xr, sc == DONE_C, xa}));
    chk("stats{max,maxa,obj}", 64'({max_dist, max_addr, obj_cnt}),
        64'({8'(e_max), 14'(e_maxa), 15'(e_obj)}));
    chk("stats{sum,thr}", 64'({dist_sum, thr_cnt}), 64'({22'(e_sum), 15'(e_thr)}));
  endtask

  task automatic lit_stats(input string nm, input int mx, input int ma, input int ob,
                           input int sm, input int tc);
    chk({nm, "_max_dist"}, 64'(max_dist), 64'(mx));
    chk({nm, "_max_addr"}, 64'(max_addr), 64'(ma));
    chk({nm, "_obj_cnt"},  64'(obj_cnt),  64'(ob));
    chk({nm, "_dist_sum"}, 64'(dist_sum), 64'(sm));
    chk({nm, "_thr_cnt"},  64'(thr_cnt),  64'(tc));
  endtask

  task automatic fill_map(input logic [7:0] v);
    for (int a = 0; a < NPIX; a++) mem[a] = v;
  endtask

  task automatic do_start(input logic [7:0] t);
    thr   = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int rds);
    cyc = 1;
    rds = int'(res_rd);
    while (done !== 1'b1 && cyc < BOUND) begin
      tick();
      cyc++;
      rds += int'(res_rd);
    end
    chk("done_seen", 64'(done), 64'(1));
  endtask

  initial begin
    int cyc;
    int rds;
    reset = 1'b0;
    start = 1'b0;
    thr   = 8'd0;
    sc    = 0;
    thr_m = 8'd0;
    e_max = 0; e_maxa = 0; e_obj = 0; e_sum = 0; e_thr = 0;
    checks = 0;
    errors = 0;
    fill_map(8'd0);

    tick();
    tick();
    chk("rst_ctrl", 64'({busy, res_rd, done, res_addr}), 64'(0));
    lit_stats("rst", 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();

    // All-zero map, thr=1.
    do_start(8'd1);
    wait_done(cyc, rds);
    chk("zero_latency", 64'(cyc), 64'(DONE_C));
    chk("zero_reads", 64'(rds), 64'(NPIX));
    lit_stats("zero", 0, 0, 0, 0, 0);
    tick();

    // Two 7s and a 3; starts at cycle 100 and in the done cycle are ignored.
    fill_map(8'd0);
    mem[300]  = 8'd7;
    mem[9000] = 8'd7;
    mem[129]  = 8'd3;
    do_start(8'd4);
    cyc = 1;
    while (done !== 1'b1 && cyc < BOUND) begin
      if (cyc == 100) begin
        start = 1'b1;
        thr   = 8'd0;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("tie_done_seen", 64'(done), 64'(1));
    chk("tie_latency", 64'(cyc), 64'(DONE_C));
    lit_stats("tie", 7, 300, 3, 17, 2);

    fill_map(8'd255);
    thr   = 8'd0;
    start = 1'b1;
    tick();
    chk("fin_start_ignored", 64'({busy, done}), 64'(0));
    lit_stats("hold", 7, 300, 3, 17, 2);
    tick();
    start = 1'b0;
    wait_done(cyc, rds);
    chk("full_latency", 64'(cyc), 64'(DONE_C));
    lit_stats("full", 255, 0, 16384, 4177920, 16384);
    tick();

    // Reset in the middle of a scan.
    fill_map(8'd0);
    mem[8321] = 8'd5;
    do_start(8'd5);
    cyc = 1;
    while (cyc < 5000) begin
      tick();
      cyc++;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_ctrl", 64'({busy, res_rd, done, res_addr}), 64'(0));
    lit_stats("abort", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();

    do_start(8'd5);
    wait_done(cyc, rds);
    chk("single_latency", 64'(cyc), 64'(DONE_C));
    lit_stats("single", 5, 8321, 1, 5, 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
